regf_bus_arb: RTL and testbench

Round-robin arbiter that shares the single `mem_*` port of a generated register file (`*_regf`) between several bus requesters, e.g. a CPU bridge and a debug port. It serialises requests, issues exactly one single-cycle regf access per grant, and returns registered read data and the error flag to the winning requester with a one-cycle acknowledge. It sits directly in front of the regf instance, in the same `main` clock domain.

---
 rtl/regf_bus_arb_pkg.sv | 21 ++
 rtl/regf_bus_arb_pick.sv | 55 +++++
 rtl/regf_bus_arb.sv | 159 +++++++++++++++
 tb/tb_regf_bus_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regf_bus_arb_pkg.sv
// Shared types and constants for the regf bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regf_bus_arb_pkg;

  // Data width of the generated register file access port.
  localparam int REGF_DATA_WIDTH = 32;

  // Arbiter sequencer: pick a winner, issue one regf access, acknowledge it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } regf_bus_arb_state_e;

  // Index width needed to address req_num requesters (at least one bit).
  function automatic int idx_width(input int req_num);
    return (req_num > 1) ? $clog2(req_num) : 1;
  endfunction

endpackage

// File: rtl/regf_bus_arb_pick.sv
// Combinational winner picker: request vector + priority pointer in, one-hot grant + index out.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Build option REGF_BUS_ARB_RR_EN: round-robin from ptr when defined, fixed priority (index 0 first) otherwise.
module regf_bus_arb_pick #(
  parameter int req_num_p = 2,
  parameter int idx_w_p   = 1
) (
  input  logic [req_num_p-1:0] req,
  input  logic [idx_w_p-1:0]   ptr,
  output logic [req_num_p-1:0] gnt,
  output logic [idx_w_p-1:0]   idx
);

  logic found;

`ifdef REGF_BUS_ARB_RR_EN
  int pos;

  // Scan requesters starting at ptr, wrapping past the top index; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < req_num_p; i++) begin
      pos = (int'(ptr) + i) % req_num_p;
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = pos[idx_w_p-1:0];
        found    = 1'b1;
      end
    end
  end
`else
  // Fixed priority has no rotating start point.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest requesting index wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < req_num_p; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        idx    = i[idx_w_p-1:0];
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regf_bus_arb.sv
// Shares one regf mem_* port between req_num_p requesters; one single-cycle access per grant.
// Latency: request seen in IDLE -> mem_ena_o next cycle -> one-cycle ack the cycle after (2 cycles).
// Backpressure: requesters hold req_ena_i until ack; requests arriving in ACCESS/RESP wait for IDLE.
// Build option REGF_BUS_ARB_RR_EN: round-robin arbitration when defined, fixed priority otherwise.
module regf_bus_arb
  import regf_bus_arb_pkg::*;
#(
  parameter int req_num_p    = 2,
  parameter int addr_width_p = 13
) (
  input  logic                                   main_clk_i,
  input  logic                                   main_rst_i,
  input  logic [req_num_p-1:0]                   req_ena_i,
  input  logic [req_num_p-1:0]                   req_wena_i,
  input  logic [req_num_p*addr_width_p-1:0]      req_addr_i,
  input  logic [req_num_p*REGF_DATA_WIDTH-1:0]   req_wdata_i,
  output logic [req_num_p-1:0]                   req_ack_o,
  output logic [REGF_DATA_WIDTH-1:0]             req_rdata_o,
  output logic                                   req_err_o,
  output logic                                   mem_ena_o,
  output logic [addr_width_p-1:0]                mem_addr_o,
  output logic                                   mem_wena_o,
  output logic [REGF_DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic [REGF_DATA_WIDTH-1:0]             mem_rdata_i,
  input  logic                                   mem_err_i
);

  localparam int idx_w_lp = idx_width(req_num_p);

  regf_bus_arb_state_e state_q, state_d;

  // Winner of the current IDLE cycle.
  logic [req_num_p-1:0]       pick_gnt;
  logic [idx_w_lp-1:0]        pick_idx;
  logic [idx_w_lp-1:0]        ptr;
  logic                       grant;

  // Command of the picked requester, muxed from the packed request buses.
  logic                       sel_wena;
  logic [addr_width_p-1:0]    sel_addr;
  logic [REGF_DATA_WIDTH-1:0] sel_wdata;

  // Latched transaction: winner, command and regf response.
  logic [req_num_p-1:0]       win_q;
  logic                       cmd_wena_q;
  logic [addr_width_p-1:0]    cmd_addr_q;
  logic [REGF_DATA_WIDTH-1:0] cmd_wdata_q;
  logic [REGF_DATA_WIDTH-1:0] rdata_q;
  logic                       err_q;

  regf_bus_arb_pick #(
    .req_num_p (req_num_p),
    .idx_w_p   (idx_w_lp)
  ) u_pick (
    .req (req_ena_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Route the winner's wena/addr/wdata slice; gnt is one-hot so at most one slice matches.
  always_comb begin
    sel_wena  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < req_num_p; k++) begin
      if (pick_gnt[k]) begin
        sel_wena  = req_wena_i[k];
        sel_addr  = req_addr_i[k*addr_width_p +: addr_width_p];
        sel_wdata = req_wdata_i[k*REGF_DATA_WIDTH +: REGF_DATA_WIDTH];
      end
    end
  end

  // Next-state logic: grant only from IDLE, then one ACCESS and one RESP cycle.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_ena_i) begin
          grant   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the command on grant and the regf response at the end of ACCESS.
  // Read data is captured on writes too; it is simply not meaningful then.
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      win_q       <= '0;
      cmd_wena_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (grant) begin
        win_q       <= pick_gnt;
        cmd_wena_q  <= sel_wena;
        cmd_addr_q  <= sel_addr;
        cmd_wdata_q <= sel_wdata;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= mem_rdata_i;
        err_q   <= mem_err_i;
      end
    end
  end

`ifdef REGF_BUS_ARB_RR_EN
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(req_num_p - 1);
  localparam logic [idx_w_lp-1:0] one_lp      = idx_w_lp'(1);

  logic [idx_w_lp-1:0] ptr_q;

  // Priority restarts just past the last winner; only a grant moves it.
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= (pick_idx == last_idx_lp) ? '0 : pick_idx + one_lp;
    end
  end

  assign ptr = ptr_q;
`else
  // Fixed priority: no pointer state, and the winner index is not needed.
  logic unused_pick_idx;
  assign unused_pick_idx = ^pick_idx;
  assign ptr = '0;
`endif

  // The regf port holds the last command; only the enable is qualified by ACCESS.
  assign mem_ena_o   = (state_q == ST_ACCESS);
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wena_o  = cmd_wena_q;
  assign mem_wdata_o = cmd_wdata_q;

  // A reset landing in RESP drops the pending ack in that same cycle.
  assign req_ack_o   = win_q & {req_num_p{(state_q == ST_RESP) && !main_rst_i}};
  assign req_rdata_o = rdata_q;
  assign req_err_o   = err_q;

endmodule

// File: tb/tb_regf_bus_arb.sv
// Directed bench for regf_bus_arb with four requesters and a small regf model.
// Latency: checks are placed 1 time unit after each rising edge.
// Backpressure: requesters hold requests until their ack, as the arbiter expects.
module tb_regf_bus_arb;

  localparam int N  = 4;
  localparam int AW = 13;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_ena;
  logic [N-1:0]    req_wena;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_ack;
  logic [31:0]     req_rdata;
  logic            req_err;
  logic            mem_ena;
  logic [AW-1:0]   mem_addr;
  logic            mem_wena;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            mem_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  regf_bus_arb #(
    .req_num_p    (N),
    .addr_width_p (AW)
  ) dut (
    .main_clk_i  (clk),
    .main_rst_i  (rst),
    .req_ena_i   (req_ena),
    .req_wena_i  (req_wena),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ack_o   (req_ack),
    .req_rdata_o (req_rdata),
    .req_err_o   (req_err),
    .mem_ena_o   (mem_ena),
    .mem_addr_o  (mem_addr),
    .mem_wena_o  (mem_wena),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_err_i   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regf model: four words at 0x0000..0x000C, everything else is a decode error.
  logic [31:0] regs [4];
  logic        mapped;
  assign mapped    = (mem_addr[12:4] == 9'd0);
  assign mem_rdata = mapped ? regs[mem_addr[3:2]] : 32'h0;
  assign mem_err   = ~mapped;

  always @(posedge clk) begin
    if (rst) begin
      regs[0] <= 32'h0000_0000;
      regs[1] <= 32'hA5A5_0003;
      regs[2] <= 32'hCAFE_0008;
      regs[3] <= 32'h3333_000C;
    end else if (mem_ena && mem_wena && mapped) begin
      regs[mem_addr[3:2]] <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  int exp_k;
  logic [31:0] exp_rd [3];

  initial begin
    rst       = 1'b1;
    req_ena   = '0;
    req_wena  = '0;
    req_addr  = '0;
    req_wdata = '0;
    exp_rd[0] = 32'h0000_0001;
    exp_rd[1] = 32'hA5A5_0003;
    exp_rd[2] = 32'hCAFE_0008;

    // Reset state.
    step();
    step();
    chk("rst_ack",   32'(req_ack), 32'h0);
    chk("rst_rdata", req_rdata, 32'h0);
    chk("rst_err",   32'(req_err), 32'h0);
    chk("rst_mena",  32'(mem_ena), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_mwena", 32'(mem_wena), 32'h0);
    chk("rst_mwdat", mem_wdata, 32'h0);
    rst = 1'b0;

    // Single read by requester 0 from 0x0004.
    req_ena = 4'b0001;
    req_addr[0*AW +: AW] = 13'h0004;
    step();
    chk("rd_c1_mena",  32'(mem_ena), 32'h1);
    chk("rd_c1_maddr", 32'(mem_addr), 32'h0004);
    chk("rd_c1_mwena", 32'(mem_wena), 32'h0);
    chk("rd_c1_ack",   32'(req_ack), 32'h0);
    step();
    chk("rd_c2_ack",   32'(req_ack), 32'h1);
    chk("rd_c2_rdata", req_rdata, 32'hA5A5_0003);
    chk("rd_c2_err",   32'(req_err), 32'h0);
    chk("rd_c2_mena",  32'(mem_ena), 32'h0);
    req_ena = 4'b0000;
    step();
    chk("rd_c3_ack",   32'(req_ack), 32'h0);
    chk("rd_c3_hold",  req_rdata, 32'hA5A5_0003);
    chk("rd_c3_maddr", 32'(mem_addr), 32'h0004);

    // Requester 1 writes 0x1 to 0x0000, then keeps its request up for a read of 0x1FFC.
    req_ena  = 4'b0010;
    req_wena = 4'b0010;
    req_addr[1*AW +: AW] = 13'h0000;
    req_wdata[1*32 +: 32] = 32'h0000_0001;
    step();
    chk("wr_mena",  32'(mem_ena), 32'h1);
    chk("wr_mwena", 32'(mem_wena), 32'h1);
    chk("wr_mwdat", mem_wdata, 32'h0000_0001);
    chk("wr_maddr", 32'(mem_addr), 32'h0000);
    step();
    chk("wr_ack", 32'(req_ack), 32'h2);
    chk("wr_err", 32'(req_err), 32'h0);
    req_wena = 4'b0000;
    req_addr[1*AW +: AW] = 13'h1FFC;
    step();
    chk("held_idle_mena", 32'(mem_ena), 32'h0);
    chk("held_idle_ack",  32'(req_ack), 32'h0);
    step();
    chk("held_acc_mena",  32'(mem_ena), 32'h1);
    chk("held_acc_maddr", 32'(mem_addr), 32'h1FFC);
    step();
    chk("unm_ack", 32'(req_ack), 32'h2);
    chk("unm_err", 32'(req_err), 32'h1);
    req_ena = 4'b0000;
    step();
    chk("unm_noack", 32'(req_ack), 32'h0);

    // Requester 2 reads back the word written above.
    req_ena = 4'b0100;
    req_addr[2*AW +: AW] = 13'h0000;
    step();
    step();
    chk("rb_ack",   32'(req_ack), 32'h4);
    chk("rb_rdata", req_rdata, 32'h0000_0001);
    req_ena = 4'b0000;
    step();

    // Contention: requesters 0..2 held high for nine transactions.
    req_addr[0*AW +: AW] = 13'h0000;
    req_addr[1*AW +: AW] = 13'h0004;
    req_addr[2*AW +: AW] = 13'h0008;
    req_ena = 4'b0111;
    for (int t = 0; t < 9; t++) begin
`ifdef REGF_BUS_ARB_RR_EN
      exp_k = t % 3;
`else
      exp_k = 0;
`endif
      step();
      chk("cont_mena", 32'(mem_ena), 32'h1);
      step();
      chk("cont_ack",   32'(req_ack), 32'(1 << exp_k));
      chk("cont_rdata", req_rdata, exp_rd[exp_k]);
      step();
      chk("cont_gap", 32'(req_ack), 32'h0);
    end
    req_ena = 4'b0000;
    step();

    // Wrap: grant 3, then requests {0,3} must go to 0.
    req_ena = 4'b1000;
    req_addr[3*AW +: AW] = 13'h000C;
    step();
    step();
    chk("wrap_g3_ack",   32'(req_ack), 32'h8);
    chk("wrap_g3_rdata", req_rdata, 32'h3333_000C);
    req_ena = 4'b0000;
    step();
    req_ena = 4'b1001;
    step();
    step();
    chk("wrap_g0_ack", 32'(req_ack), 32'h1);
    req_ena = 4'b0000;
    step();

    // Reset during RESP: ack suppressed immediately, everything cleared next cycle.
    req_ena = 4'b0100;
    req_addr[2*AW +: AW] = 13'h0008;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstresp_ack", 32'(req_ack), 32'h0);
    req_ena = 4'b0000;
    step();
    chk("rstresp_ack2",  32'(req_ack), 32'h0);
    chk("rstresp_rdata", req_rdata, 32'h0);
    chk("rstresp_mena",  32'(mem_ena), 32'h0);
    chk("rstresp_maddr", 32'(mem_addr), 32'h0);
    rst = 1'b0;
    // Pointer back at 0: requests {1,3} pick 1.
    req_ena = 4'b1010;
    req_addr[1*AW +: AW] = 13'h0004;
    step();
    chk("ptr0_mena", 32'(mem_ena), 32'h1);
    step();
    chk("ptr0_ack",   32'(req_ack), 32'h2);
    chk("ptr0_rdata", req_rdata, 32'hA5A5_0003);
    req_ena = 4'b0000;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
